router_sync_nch: RTL and testbench
==================================

Name: router_sync_nch

Overview:
- Parametrised successor of the 3-port router synchroniser; sits between the router FSM/register block and NUM_CH output FIFOs.
- Latches the destination address on header detect and steers the write enable to the addressed FIFO.
- Muxes the addressed FIFO's full flag back to the FSM and drives per-channel valid outputs.
- Runs per-channel read-timeout counters that pulse soft resets; also flags out-of-range destination addresses, which the 3-port version silently dropped.

Parameters:
- NUM_CH, 3, number of output channels/FIFOs (2..8)
- ADDR_W, 2, width of data_in address field; requires 2**ADDR_W >= NUM_CH
- TIMEOUT, 30, consecutive unread-valid cycles before soft reset (1..2**CNT_W-1)
- CNT_W, 5, timeout counter width

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- detect_add  in  1  header-byte strobe from FSM; latch data_in
- write_enb_reg  in  1  FSM write permission
- data_in  in  ADDR_W  destination address field of header
- full  in  NUM_CH  per-FIFO full flags
- empty  in  NUM_CH  per-FIFO empty flags
- read_enb  in  NUM_CH  per-FIFO read enables from the output side
- vld_out  out  NUM_CH  per-channel valid (not empty)
- write_enb  out  NUM_CH  one-hot FIFO write enable
- fifo_full  out  1  full flag of the addressed FIFO
- soft_reset  out  NUM_CH  per-channel one-cycle soft-reset pulse
- addr_err  out  1  latched address is out of range (>= NUM_CH)

Behaviour:
- Reset values (reset=1 at edge): addr_q=0, addr_err=0, all counters=0, soft_reset=0. Combinational outputs follow from this state.
- Address latch:
  - On edge with detect_add=1: addr_q<=data_in and addr_err<=(data_in>=NUM_CH).
  - Otherwise both hold.
  - Latency: one cycle from detect_add to new steering.
- write_enb (combinational):
  - Bit addr_q is high iff write_enb_reg=1 and addr_err=0.
  - All other bits are 0.
  - At most one bit is ever high.
- fifo_full (combinational): equals full[addr_q] when addr_err=0; 0 when addr_err=1.
- vld_out[i] = ~empty[i], combinational, with no dependence on reset.
- Timeout counter, per channel i, evaluated each edge when reset=0:
  - vld_out[i]=0: cnt<=0, soft_reset[i]<=0.
  - vld_out[i]=1 and read_enb[i]=1: cnt<=0, soft_reset[i]<=0.
  - vld_out[i]=1, read_enb[i]=0, cnt==TIMEOUT: soft_reset[i]<=1, cnt<=0.
  - vld_out[i]=1, read_enb[i]=0, cnt!=TIMEOUT: soft_reset[i]<=0, cnt<=cnt+1.
- Timing consequences of the counter rules:
  - If empty[i] falls and read_enb[i] stays 0, soft_reset[i] goes high after edge TIMEOUT+1, stays high exactly one cycle, and repeats every TIMEOUT+1 edges while the condition persists.
  - Unlike the 3-port block, soft_reset clears when the channel empties.
- Channels are fully independent. Simultaneous timeouts on several channels pulse together.
- A read at the same edge the counter reaches TIMEOUT suppresses the pulse; read has priority.
- detect_add and write_enb_reg together in the same cycle: write_enb uses the old addr_q in that cycle.
- reset asserted mid-count: counters and pulses clear at that edge, and an in-flight pulse is truncated.
- No arithmetic overflow: the counter never exceeds TIMEOUT.

Optional Feature:
- Macro: ROUTER_SYNC_TIMEOUT_STS_EN.
- When defined, adds two ports:
  - timeout_sts out NUM_CH: per-channel sticky flag, set at the edge soft_reset[i] is registered high.
  - sts_clr in NUM_CH: clears the corresponding flag at the edge it is high. If set and clear coincide, set wins.
- timeout_sts resets to 0.
- When undefined, neither port nor the status register exists, and the remaining behaviour is identical.

Test Plan:
- NUM_CH=3: reset 2 cycles, then detect_add with data_in=2'b01, then write_enb_reg=1 -> write_enb=3'b010 from the next cycle; full=3'b010 -> fifo_full=1; full=3'b001 -> fifo_full=0.
- data_in=2'b11 latched, write_enb_reg=1 -> addr_err=1, write_enb=0, fifo_full=0 even with full=3'b111; next detect_add with 2'b00 -> addr_err=0, write_enb=3'b001.
- empty[0] falls, read_enb[0]=0, TIMEOUT=30 -> soft_reset[0] high for one cycle after edge 31 and again after edge 62; read_enb[0]=1 at edge 20 -> no pulse until edge 51.
- Channels 1 and 2 go non-empty on the same edge, with channel 2 read at the edge its counter equals TIMEOUT -> soft_reset[1] pulses, soft_reset[2] stays 0.
- Reset asserted at counter=15 -> counter=0 and soft_reset=0 next cycle; a subsequent timeout takes the full TIMEOUT+1 edges.
- With ROUTER_SYNC_TIMEOUT_STS_EN defined:
  - Channel 0 times out -> timeout_sts[0]=1 and holds.
  - sts_clr[0] pulse -> 0.
  - sts_clr coincident with a new pulse -> stays 1.

Source files
------------

// File: rtl/router_sync_nch.sv
// rtl/router_sync_nch.sv - NUM_CH-channel router synchroniser: address latch, write steering, read timeouts
// Optional macro ROUTER_SYNC_TIMEOUT_STS_EN adds sticky per-channel timeout status (timeout_sts / sts_clr).
module router_sync_nch #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              detect_add,
    input  logic              write_enb_reg,
    input  logic [ADDR_W-1:0] data_in,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] read_enb,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
`ifdef ROUTER_SYNC_TIMEOUT_STS_EN
    ,
    output logic [NUM_CH-1:0] timeout_sts,
    input  logic [NUM_CH-1:0] sts_clr
`endif
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] sr_d;

    // Channel is valid whenever its FIFO holds data, independent of reset.
    assign vld_out = ~empty;

    // Latch destination on header strobe; out-of-range addresses are flagged, not steered.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q   <= '0;
            addr_err <= 1'b0;
        end else if (detect_add) begin
            addr_q   <= data_in;
            addr_err <= (32'(data_in) >= NUM_CH);
        end
    end

    // One-hot write steering and full-flag mux; loop compare keeps indexing in range.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!addr_err && addr_q == ADDR_W'(i)) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    // Next-state of the per-channel timeout counters; a read always wins over a timeout.
    always_comb begin
        sr_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = '0;
            if (vld_out[i] && !read_enb[i]) begin
                if (cnt[i] == TMO) begin
                    sr_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // Register counters and soft-reset pulses; reset truncates any in-flight pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
            soft_reset <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_d[i];
            soft_reset <= sr_d;
        end
    end

`ifdef ROUTER_SYNC_TIMEOUT_STS_EN
    // Sticky timeout status; a new pulse takes priority over a coincident clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_sts <= '0;
        end else begin
            timeout_sts <= (timeout_sts & ~sts_clr) | sr_d;
        end
    end
`endif

endmodule

// File: tb/tb_router_sync_nch.sv
// tb/tb_router_sync_nch.sv - directed self-checking bench for router_sync_nch (NUM_CH=3, TIMEOUT=30)
module tb_router_sync_nch;

    logic       clock = 1'b0;
    logic       reset;
    logic       detect_add;
    logic       write_enb_reg;
    logic [1:0] data_in;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] read_enb;
    logic [2:0] vld_out;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic [2:0] soft_reset;
    logic       addr_err;
    logic [2:0] timeout_sts;
    logic [2:0] sts_clr;

    int tests  = 0;
    int failed = 0;

    router_sync_nch #(
        .NUM_CH (3),
        .ADDR_W (2),
        .TIMEOUT(30),
        .CNT_W  (5)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .detect_add   (detect_add),
        .write_enb_reg(write_enb_reg),
        .data_in      (data_in),
        .full         (full),
        .empty        (empty),
        .read_enb     (read_enb),
        .vld_out      (vld_out),
        .write_enb    (write_enb),
        .fifo_full    (fifo_full),
        .soft_reset   (soft_reset),
        .addr_err     (addr_err)
`ifdef ROUTER_SYNC_TIMEOUT_STS_EN
        ,
        .timeout_sts  (timeout_sts),
        .sts_clr      (sts_clr)
`endif
    );

`ifndef ROUTER_SYNC_TIMEOUT_STS_EN
    assign timeout_sts = '0;
`endif

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; detect_add = 1'b0; write_enb_reg = 1'b0; data_in = 2'b00;
        full = 3'b000; empty = 3'b111; read_enb = 3'b000; sts_clr = 3'b000;
        tick(); tick();
        check("rst_addr_err", 32'(addr_err), 32'd0);
        check("rst_soft_reset", 32'(soft_reset), 32'd0);
        check("rst_write_enb", 32'(write_enb), 32'd0);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_vld_out", 32'(vld_out), 32'd0);

        // Address latch; write_enb uses the old address during the detect cycle
        reset = 1'b0;
        detect_add = 1'b1; data_in = 2'b01; write_enb_reg = 1'b1;
        #1;
        check("coincide_old_addr", 32'(write_enb), 32'b001);
        tick();
        detect_add = 1'b0;
        #1;
        check("we_addr1", 32'(write_enb), 32'b010);
        full = 3'b010; #1;
        check("ff_addr1_set", 32'(fifo_full), 32'd1);
        full = 3'b001; #1;
        check("ff_addr1_clr", 32'(fifo_full), 32'd0);

        // Out-of-range destination
        detect_add = 1'b1; data_in = 2'b11;
        tick();
        detect_add = 1'b0; full = 3'b111;
        #1;
        check("err_flag", 32'(addr_err), 32'd1);
        check("err_we", 32'(write_enb), 32'd0);
        check("err_ff", 32'(fifo_full), 32'd0);
        detect_add = 1'b1; data_in = 2'b00;
        tick();
        detect_add = 1'b0;
        #1;
        check("recover_err", 32'(addr_err), 32'd0);
        check("recover_we", 32'(write_enb), 32'b001);
        check("recover_ff", 32'(fifo_full), 32'd1);
        write_enb_reg = 1'b0; full = 3'b000; #1;
        check("we_idle", 32'(write_enb), 32'd0);

        // Channel 0 unread: pulses after edges 31 and 62
        empty = 3'b110; #1;
        check("vld_ch0", 32'(vld_out), 32'b001);
        for (int e = 1; e <= 63; e++) begin
            tick();
            check($sformatf("to_ch0_e%0d", e), 32'(soft_reset), (e == 31 || e == 62) ? 32'b001 : 32'd0);
        end
        empty = 3'b111;
        tick();
        check("drain_clear", 32'(soft_reset), 32'd0);

        // Read at edge 20 restarts the count: pulse at edge 51
        empty = 3'b110;
        for (int e = 1; e <= 52; e++) begin
            read_enb = (e == 20) ? 3'b001 : 3'b000;
            tick();
            check($sformatf("rd_ch0_e%0d", e), 32'(soft_reset), (e == 51) ? 32'b001 : 32'd0);
        end
        read_enb = 3'b000; empty = 3'b111;
        tick();

        // Channels 1 and 2 together; channel 2 read exactly at its timeout edge
        empty = 3'b001;
        for (int e = 1; e <= 32; e++) begin
            read_enb = (e == 31) ? 3'b100 : 3'b000;
            tick();
            check($sformatf("ch12_e%0d", e), 32'(soft_reset), (e == 31) ? 32'b010 : 32'd0);
        end
        read_enb = 3'b000; empty = 3'b111;
        tick();

        // All channels together pulse together
        empty = 3'b000;
        for (int e = 1; e <= 32; e++) begin
            tick();
            check($sformatf("all_e%0d", e), 32'(soft_reset), (e == 31) ? 32'b111 : 32'd0);
        end
        empty = 3'b111;
        tick();

        // Reset at count 15 restarts the full timeout
        empty = 3'b110;
        for (int e = 1; e <= 15; e++) tick();
        reset = 1'b1;
        tick();
        check("midrst_sr", 32'(soft_reset), 32'd0);
        reset = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            tick();
            check($sformatf("post_rst_e%0d", e), 32'(soft_reset), (e == 31) ? 32'b001 : 32'd0);
        end
        empty = 3'b111;

`ifdef ROUTER_SYNC_TIMEOUT_STS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("sts_rst", 32'(timeout_sts), 32'd0);
        empty = 3'b110;
        for (int e = 1; e <= 33; e++) begin
            tick();
            if (e >= 30) check($sformatf("sts_e%0d", e), 32'(timeout_sts), (e >= 31) ? 32'b001 : 32'd0);
        end
        sts_clr = 3'b001;
        tick();
        sts_clr = 3'b000;
        check("sts_cleared", 32'(timeout_sts), 32'd0);
        for (int e = 35; e <= 61; e++) tick();
        check("sts_before_2nd", 32'(timeout_sts), 32'd0);
        sts_clr = 3'b001;
        tick();
        sts_clr = 3'b000;
        check("sts_set_wins", 32'(timeout_sts), 32'b001);
        check("sts_sr_2nd", 32'(soft_reset), 32'b001);
        empty = 3'b111;
`else
        check("sts_absent", 32'(timeout_sts), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
